// File: rtl/score_table_ranked.sv
// score_table_ranked
//   Ranked high-score table. Keeps the top DEPTH (user_id, score) pairs sorted
//   by descending score. A game-over edge starts a sequential insert: SCAN
//   looks for the insert position one entry per cycle, and SHIFT moves the
//   lower entries down one per cycle before writing the new pair. In SHOW the
//   buttons page through the table, one entry at a time, to the display.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   buttons[2:0]   [0]=next [1]=prev [2]=exit, level inputs (edges detected here)
//   user_id        player id, captured on the game-over edge
//   score          final score, captured on the game-over edge
//   game_state     game FSM state; GAME_OVER on a rising edge triggers an insert
//   busy           high while SCAN or SHIFT is running
//   entry_count    number of valid entries, 0..DEPTH
//   scoreboard_eof one-cycle pulse on wrap past the last entry or on exit
//   display_data   {id, score} at the cursor while in SHOW, otherwise 0
module score_table_ranked #(
    parameter int         ID_W      = 16,
    parameter int         SCORE_W   = 16,
    parameter int         DEPTH     = 8,
    parameter logic [1:0] GAME_OVER = 2'd2,
    parameter int         IDX_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                buttons,
    input  logic [ID_W-1:0]           user_id,
    input  logic [SCORE_W-1:0]        score,
    input  logic [1:0]                game_state,
    output logic                      busy,
    output logic [IDX_W-1:0]          entry_count,
    output logic                      scoreboard_eof,
    output logic [ID_W+SCORE_W-1:0]   display_data
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_I  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] ONE_I   = IDX_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_SHOW  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [1:0]               gs_prev_q;
    logic [2:0]               btn_prev_q;
    logic [ID_W-1:0]          pend_id_q, pend_id_d;
    logic [SCORE_W-1:0]       pend_sc_q, pend_sc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;      // scan index in SCAN, move target in SHIFT
    logic [IDX_W-1:0]         pos_q, pos_d;
    logic [IDX_W-1:0]         count_q, count_d;
    logic [IDX_W-1:0]         cursor_q, cursor_d;
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic                     eof_q, eof_d;
    logic [ID_W+SCORE_W-1:0]  disp_q, disp_d;
    logic [ID_W-1:0]          tbl_id_q [DEPTH];
    logic [ID_W-1:0]          tbl_id_d [DEPTH];
    logic [SCORE_W-1:0]       tbl_sc_q [DEPTH];
    logic [SCORE_W-1:0]       tbl_sc_d [DEPTH];

    logic                     trig;
    logic [2:0]               rise;
    logic [SCORE_W-1:0]       sc_at_idx;
    logic                     scan_hit;
    logic [IDX_W-1:0]         idx_m1;
    logic [ADDR_W-1:0]        cur_a;

    always_comb begin
        trig   = (game_state == GAME_OVER) && (gs_prev_q != GAME_OVER);
        rise   = buttons & ~btn_prev_q;
        idx_m1 = idx_q - ONE_I;
        cur_a  = cursor_q[ADDR_W-1:0];

        // idx_q reaches DEPTH only when the table is full; the count match
        // already decides the scan there, so the read value is irrelevant.
        sc_at_idx = '0;
        if (idx_q < DEPTH_I) sc_at_idx = tbl_sc_q[idx_q[ADDR_W-1:0]];
        // Strict '>' keeps the older entry ahead on a tie.
        scan_hit = (idx_q == count_q) || (pend_sc_q > sc_at_idx);

        state_d   = state_q;
        pend_id_d = pend_id_q;
        pend_sc_d = pend_sc_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        count_d   = count_q;
        cursor_d  = cursor_q;
        valid_d   = valid_q;
        eof_d     = 1'b0;
        tbl_id_d  = tbl_id_q;
        tbl_sc_d  = tbl_sc_q;

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    pend_id_d = user_id;
                    pend_sc_d = score;
                    idx_d     = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_hit) begin
                    pos_d = idx_q;
                    if (idx_q == DEPTH_I) begin
                        // Full table and the new score does not beat the last entry.
                        cursor_d = '0;
                        state_d  = S_SHOW;
                    end else begin
                        idx_d   = (count_q < DEPTH_I) ? count_q : LAST_I;
                        state_d = S_SHIFT;
                    end
                end else begin
                    idx_d = idx_q + ONE_I;
                end
            end
            S_SHIFT: begin
                if (idx_q == pos_q) begin
                    tbl_id_d[pos_q[ADDR_W-1:0]] = pend_id_q;
                    tbl_sc_d[pos_q[ADDR_W-1:0]] = pend_sc_q;
                    valid_d[pos_q[ADDR_W-1:0]]  = 1'b1;
                    count_d  = (count_q == DEPTH_I) ? count_q : count_q + ONE_I;
                    cursor_d = pos_q;
                    state_d  = S_SHOW;
                end else begin
                    // When full, the first move overwrites the bottom entry.
                    tbl_id_d[idx_q[ADDR_W-1:0]] = tbl_id_q[idx_m1[ADDR_W-1:0]];
                    tbl_sc_d[idx_q[ADDR_W-1:0]] = tbl_sc_q[idx_m1[ADDR_W-1:0]];
                    valid_d[idx_q[ADDR_W-1:0]]  = 1'b1;
                    idx_d = idx_m1;
                end
            end
            default: begin // S_SHOW
                if (trig) begin
                    pend_id_d = user_id;
                    pend_sc_d = score;
                    idx_d     = '0;
                    state_d   = S_SCAN;
                end else if (rise[2]) begin
                    eof_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (rise[0]) begin
                    if (cursor_q == count_q - ONE_I) begin
                        cursor_d = '0;
                        eof_d    = 1'b1;
                    end else begin
                        cursor_d = cursor_q + ONE_I;
                    end
                end else if (rise[1]) begin
                    if (cursor_q != '0) cursor_d = cursor_q - ONE_I;
                end
            end
        endcase

        disp_d = '0;
        if (state_q == S_SHOW && valid_q[cur_a]) disp_d = {tbl_id_q[cur_a], tbl_sc_q[cur_a]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gs_prev_q  <= '0;
            btn_prev_q <= '0;
            idx_q      <= '0;
            pos_q      <= '0;
            count_q    <= '0;
            cursor_q   <= '0;
            valid_q    <= '0;
            eof_q      <= 1'b0;
            disp_q     <= '0;
        end else begin
            state_q    <= state_d;
            gs_prev_q  <= game_state;
            btn_prev_q <= buttons;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            count_q    <= count_d;
            cursor_q   <= cursor_d;
            valid_q    <= valid_d;
            eof_q      <= eof_d;
            disp_q     <= disp_d;
        end
    end

    // Table contents and the pending pair are gated by the valid bits and the
    // FSM, so they need no reset.
    always_ff @(posedge clk) begin
        pend_id_q <= pend_id_d;
        pend_sc_q <= pend_sc_d;
        tbl_id_q  <= tbl_id_d;
        tbl_sc_q  <= tbl_sc_d;
    end

    assign busy           = (state_q == S_SCAN) || (state_q == S_SHIFT);
    assign entry_count    = count_q;
    assign scoreboard_eof = eof_q;
    assign display_data   = disp_q;

endmodule

// File: tb/tb_score_table_ranked.sv
// tb_score_table_ranked
//   Directed bench for score_table_ranked. Stimulus pushes expectations into
//   three queues (display transitions, eof pulses, completed inserts); a monitor
//   on the falling clock edge pops and compares whenever the DUT presents them.
module tb_score_table_ranked;

    localparam int IDX_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  buttons = '0;
    logic [15:0] user_id = '0;
    logic [15:0] score = '0;
    logic [1:0]  game_state = '0;
    logic        busy;
    logic [IDX_W-1:0] entry_count;
    logic        scoreboard_eof;
    logic [31:0] display_data;

    score_table_ranked dut (
        .clk            (clk),
        .rst            (rst),
        .buttons        (buttons),
        .user_id        (user_id),
        .score          (score),
        .game_state     (game_state),
        .busy           (busy),
        .entry_count    (entry_count),
        .scoreboard_eof (scoreboard_eof),
        .display_data   (display_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [IDX_W-1:0] cnt;
        int               blen;
    } ins_t;

    ins_t        ins_q[$];
    logic [31:0] disp_q[$];
    string       eof_q[$];

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_disp = '0;
    logic        busy_prev = 1'b0;
    int          busy_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every display transition, eof pulse and end of busy is matched
    // against the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (display_data !== last_disp) begin
                if (disp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL display_unexpected: got 0x%0h expected no change from 0x%0h",
                             display_data, last_disp);
                end else begin
                    chk("display", display_data, disp_q.pop_front());
                end
                last_disp = display_data;
            end
            if (scoreboard_eof) begin
                checks++;
                if (eof_q.size() == 0) begin
                    errors++;
                    $display("FAIL eof_unexpected: got pulse expected none");
                end else begin
                    void'(eof_q.pop_front());
                end
            end
            if (busy) busy_len++;
            if (!busy && busy_prev) begin
                if (ins_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL insert_unexpected: got busy for %0d cycles expected none", busy_len);
                end else begin
                    ins_t e;
                    e = ins_q.pop_front();
                    chk({e.name, "_busy"}, busy_len, e.blen);
                    chk({e.name, "_count"}, {28'd0, entry_count}, {28'd0, e.cnt});
                end
                busy_len = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic expect_insert(input string name, input logic [IDX_W-1:0] cnt, input int blen,
                                 input logic [31:0] disp, input bit from_show);
        ins_t e;
        e.name = name; e.cnt = cnt; e.blen = blen;
        ins_q.push_back(e);
        if (from_show) disp_q.push_back(32'h0);
        disp_q.push_back(disp);
    endtask

    task automatic game_over(input logic [15:0] id, input logic [15:0] sc);
        @(negedge clk);
        user_id = id; score = sc; game_state = 2'd2;
        @(negedge clk);
        game_state = 2'd0;
        repeat (20) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] b);
        @(negedge clk);
        buttons = b;
        repeat (2) @(negedge clk);
        buttons = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_count", {28'd0, entry_count}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_eof", {31'd0, scoreboard_eof}, 32'd0);
        chk("reset_display", display_data, 32'd0);
        last_disp = display_data;
        mon_en = 1'b1;

        // Single insert into an empty table.
        expect_insert("first", 4'd1, 2, 32'h0001_0064, 1'b0);
        game_over(16'h0001, 16'd100);

        // Ordering: table becomes 300,200,100,50.
        expect_insert("ins50", 4'd2, 3, 32'h0002_0032, 1'b1);
        game_over(16'h0002, 16'd50);
        expect_insert("ins300", 4'd3, 4, 32'h0003_012C, 1'b1);
        game_over(16'h0003, 16'd300);
        expect_insert("ins200", 4'd4, 5, 32'h0004_00C8, 1'b1);
        game_over(16'h0004, 16'd200);
        disp_q.push_back(32'h0001_0064);
        press(3'b001);
        disp_q.push_back(32'h0002_0032);
        press(3'b001);
        disp_q.push_back(32'h0003_012C);
        eof_q.push_back("wrap4");
        press(3'b001);
        press(3'b010);
        press(3'b010);
        disp_q.push_back(32'h0004_00C8);
        press(3'b001);
        disp_q.push_back(32'h0);
        eof_q.push_back("exit1");
        press(3'b100);

        // Fill to DEPTH with 80..10, then a discarded 5 and a 45 at idx 4.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            expect_insert("fill", IDX_W'(k + 1), k + 2,
                          {16'h0010 + 16'(k), 16'(80 - 10 * k)}, k != 0);
            game_over(16'h0010 + 16'(k), 16'(80 - 10 * k));
        end
        expect_insert("ins5_discard", 4'd8, 9, 32'h0010_0050, 1'b1);
        game_over(16'h0020, 16'd5);
        expect_insert("ins45", 4'd8, 9, 32'h0021_002D, 1'b1);
        game_over(16'h0021, 16'd45);
        disp_q.push_back(32'h0014_0028);
        press(3'b001);
        disp_q.push_back(32'h0015_001E);
        press(3'b001);
        disp_q.push_back(32'h0016_0014);
        press(3'b001);
        disp_q.push_back(32'h0010_0050);
        eof_q.push_back("wrap8");
        press(3'b001);
        // next and exit together: exit wins.
        disp_q.push_back(32'h0);
        eof_q.push_back("exit2");
        press(3'b101);
        press(3'b001);

        // Ties keep the older entry first.
        do_reset();
        expect_insert("tieA", 4'd1, 2, 32'h000A_0064, 1'b0);
        game_over(16'h000A, 16'd100);
        expect_insert("tieB", 4'd2, 3, 32'h000B_0064, 1'b1);
        game_over(16'h000B, 16'd100);
        disp_q.push_back(32'h000A_0064);
        press(3'b010);
        press(3'b010);
        disp_q.push_back(32'h000B_0064);
        press(3'b001);

        // A second game-over edge during SHIFT is ignored.
        expect_insert("ins200_retrig", 4'd3, 4, 32'h000C_00C8, 1'b1);
        @(negedge clk);
        user_id = 16'h000C; score = 16'd200; game_state = 2'd2;
        @(negedge clk);
        game_state = 2'd0;
        @(negedge clk);
        game_state = 2'd2;
        @(negedge clk);
        game_state = 2'd0;
        repeat (20) @(negedge clk);

        // Reset in the middle of SHIFT empties the table.
        begin
            ins_t e;
            e.name = "rst_mid_shift"; e.cnt = 4'd0; e.blen = 3;
            ins_q.push_back(e);
            disp_q.push_back(32'h0);
        end
        @(negedge clk);
        user_id = 16'h000D; score = 16'd150; game_state = 2'd2;
        @(negedge clk);
        game_state = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_display", display_data, 32'h0);
        chk("rst_count", {28'd0, entry_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_insert("after_rst", 4'd1, 2, 32'h000E_0007, 1'b0);
        game_over(16'h000E, 16'd7);

        repeat (5) @(negedge clk);
        chk("pending_display", disp_q.size(), 32'd0);
        chk("pending_eof", eof_q.size(), 32'd0);
        chk("pending_insert", ins_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
